// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage: FSM encoding,
// fetch-queue entry layout and PC helpers.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_e;

  // One fetch-queue entry: the instruction word tagged with the PC it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fq_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_queue.sv
// Synchronous FIFO of {pc, instr} entries between fetch and decode.
// Circular pointers wrap naturally because DEPTH is a power of two; flush empties it.
module fetch_unit_queue
  import fetch_unit_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  fq_entry_t     push_data,
  input  logic          pop,
  input  logic          flush,
  output fq_entry_t     head,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

  fq_entry_t      mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty = (count == '0);
  assign full  = (count == CNT_MAX);
  assign head  = mem[rd_ptr];

  // Flush overrides both ports; a push at full is only taken alongside a pop.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the simulator evaluates blocks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; entries are only ever
  // observed through count, so stale contents are harmless and the array can
  // map onto plain flops or a register file without a reset network.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one word fetch at a time to the
// ICache, queues returned words for decode and handles redirects across misses.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter  logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter  int unsigned FQ_DEPTH = 4,
  localparam int unsigned CW       = $clog2(FQ_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  output logic          ic_req_valid,
  output logic [31:0]   ic_req_addr,
  input  logic          ic_req_ready,
  input  logic          ic_resp_valid,
  input  logic [31:0]   ic_resp_data,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_instr,
  output logic [31:0]   out_pc,
  output logic [CW-1:0] fq_count
);

  localparam logic [31:0] RESET_PC_ALIGNED = align_word(RESET_PC);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic         started_q;

  logic         fq_push;
  logic         fq_pop;
  logic         fq_flush;
  logic         fq_empty;
  logic         fq_full;
  fq_entry_t    fq_head;
  fq_entry_t    fq_push_data;
  logic [31:0]  redirect_target;

  assign redirect_target = align_word(redirect_pc);
  assign ic_req_addr     = pc_q;
  assign fq_push_data    = '{pc: pc_q, instr: ic_resp_data};
  assign fq_flush        = redirect_valid;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case/if tree leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    ic_req_valid = 1'b0;
    fq_push      = 1'b0;

    case (state_q)
      ST_FETCH: begin
        ic_req_valid = started_q && !fq_full;
        if (redirect_valid) begin
          // A busy cache is refilling our old address; let it finish first.
          if (ic_req_ready) begin
            pc_d = redirect_target;
          end else begin
            pend_pc_d = redirect_target;
            state_d   = ST_DRAIN;
          end
        end else if (ic_req_valid && ic_resp_valid) begin
          fq_push = 1'b1;
          pc_d    = pc_q + 32'd4;
        end
      end

      ST_DRAIN: begin
        // Keep the refill address live until the cache answers, then drop the word.
        ic_req_valid = 1'b1;
        if (ic_resp_valid) begin
          pc_d    = redirect_valid ? redirect_target : pend_pc_q;
          state_d = ST_FETCH;
        end else if (redirect_valid) begin
          pend_pc_d = redirect_target;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC_ALIGNED;
      pend_pc_q <= RESET_PC_ALIGNED;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      started_q <= 1'b1;
    end
  end

  fetch_unit_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (fq_push),
    .push_data (fq_push_data),
    .pop       (fq_pop),
    .flush     (fq_flush),
    .head      (fq_head),
    .empty     (fq_empty),
    .full      (fq_full),
    .count     (fq_count)
  );

  assign out_valid = !fq_empty;
  assign fq_pop    = out_valid && out_ready;
  assign out_instr = out_valid ? fq_head.instr : '0;
  assign out_pc    = out_valid ? fq_head.pc    : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: line-based ICache model with a fixed refill delay, a
// transaction-level fetch model checked every cycle, and directed scenarios.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ic_req_valid;
  logic [31:0] ic_req_addr;
  logic        ic_req_ready;
  logic        ic_resp_valid;
  logic [31:0] ic_resp_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  fq_count;

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .FQ_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ic_req_valid   (ic_req_valid),
    .ic_req_addr    (ic_req_addr),
    .ic_req_ready   (ic_req_ready),
    .ic_resp_valid  (ic_resp_valid),
    .ic_resp_data   (ic_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fq_count       (fq_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  // ICache: 32-byte lines, miss holds ready low for 3 cycles, fill uses the live address.
  logic [127:0] line_ok = '0;
  int           miss_cnt;

  assign ic_req_ready  = (miss_cnt == 0);
  assign ic_resp_valid = ic_req_valid && ic_req_ready && line_ok[ic_req_addr[11:5]];
  assign ic_resp_data  = ic_resp_valid ? mem_word(ic_req_addr) : 32'hDEAD_BEEF;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      miss_cnt <= 0;
    end else if (miss_cnt == 0) begin
      if (ic_req_valid && !line_ok[ic_req_addr[11:5]]) miss_cnt <= 3;
    end else begin
      if (miss_cnt == 1) line_ok[ic_req_addr[11:5]] <= 1'b1;
      miss_cnt <= miss_cnt - 1;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Fetch model: PC, a queue of {pc,instr}, and a pending redirect while a refill drains.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_pend = RESET_PC;
  logic [31:0] m_tgt;
  bit          m_started = 1'b0;
  bit          m_drain = 1'b0;
  bit          m_req;

  always @(negedge clk) begin
    if (!reset) begin
      mq.delete();
      m_pc      = RESET_PC;
      m_pend    = RESET_PC;
      m_started = 1'b0;
      m_drain   = 1'b0;
    end

    m_req = m_started && (m_drain || (mq.size() < DEPTH));
    check("m_req_valid", ic_req_valid, m_req);
    check("m_req_addr",  ic_req_addr,  m_pc);
    check("m_out_valid", out_valid,    mq.size() != 0);
    check("m_fq_count",  fq_count,     mq.size());
    if (mq.size() != 0) begin
      check("m_out_pc",    out_pc,    mq[0].pc);
      check("m_out_instr", out_instr, mq[0].instr);
    end

    if (reset) begin
      if (!m_started) begin
        m_started = 1'b1;
      end else if (redirect_valid) begin
        m_tgt = {redirect_pc[31:2], 2'b00};
        mq.delete();
        if (m_drain) begin
          if (ic_resp_valid) begin
            m_pc    = m_tgt;
            m_drain = 1'b0;
          end else begin
            m_pend = m_tgt;
          end
        end else if (ic_req_ready) begin
          m_pc = m_tgt;
        end else begin
          m_pend  = m_tgt;
          m_drain = 1'b1;
        end
      end else begin
        if (out_ready && mq.size() != 0) void'(mq.pop_front());
        if (m_drain) begin
          if (ic_resp_valid) begin
            m_pc    = m_pend;
            m_drain = 1'b0;
          end
        end else if (m_req && ic_resp_valid) begin
          mq.push_back('{m_pc, mem_word(m_pc)});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    redirect_pc    = pc;
    redirect_valid = 1'b1;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_out_valid(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check(name, ok, 1'b1);
  endtask

  task automatic wait_resp_holding(input string name, input logic [31:0] addr);
    bit ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check({name, "_addr"},  ic_req_addr,  addr);
      check({name, "_valid"}, ic_req_valid, 1'b1);
      if (ic_resp_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check({name, "_hit"}, ok, 1'b1);
  endtask

  initial begin
    int  held;
    bit  ok;

    // Reset state
    repeat (3) step();
    check("rst_req_valid", ic_req_valid, 1'b0);
    check("rst_req_addr",  ic_req_addr,  32'h0);
    check("rst_out_valid", out_valid,    1'b0);
    check("rst_fq_count",  fq_count,     3'd0);
    check("rst_out_pc",    out_pc,       32'h0);
    check("rst_out_instr", out_instr,    32'h0);
    reset = 1'b1;

    // 1: cold cache, address 0 held through the refill
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ic_req_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("t1_req_seen",   ok,          1'b1);
    check("t1_first_addr", ic_req_addr, 32'h0);
    held = 0;
    ok   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ic_resp_valid) begin
        ok = 1'b1;
        break;
      end
      if (ic_req_valid && ic_req_addr == 32'h0) held++;
      step();
    end
    check("t1_hit_seen",    ok,   1'b1);
    check("t1_miss_cycles", held, 4);

    // 2: warm line streams 0x0..0x1C with no bubbles, then 0x20 misses
    for (int i = 0; i < 8; i++) begin
      step();
      check("t2_out_valid", out_valid, 1'b1);
      check("t2_out_pc",    out_pc,    32'(i * 4));
      if (i == 0) check("t2_first_instr", out_instr, 32'hC3A5_0000);
    end
    step();
    check("t2_bubble", out_valid, 1'b0);

    // 3: decode stalled, queue saturates, release resumes at 0x10
    reset = 1'b0;
    step();
    step();
    out_ready = 1'b0;
    reset     = 1'b1;
    repeat (10) step();
    check("t3_fq_full",   fq_count,     3'd4);
    check("t3_req_off",   ic_req_valid, 1'b0);
    check("t3_pc_held",   ic_req_addr,  32'h10);
    check("t3_head_pc",   out_pc,       32'h0);
    out_ready = 1'b1;
    step();
    check("t3_req_on",    ic_req_valid,  1'b1);
    check("t3_req_addr",  ic_req_addr,   32'h10);
    check("t3_req_hit",   ic_resp_valid, 1'b1);
    check("t3_head_next", out_pc,        32'h4);

    // 4: redirect to an unaligned target during a hit stream
    step();
    check("t4_ready", ic_req_ready, 1'b1);
    pulse_redirect(32'h0000_0103);
    check("t4_flushed",   fq_count,    3'd0);
    check("t4_no_out",    out_valid,   1'b0);
    check("t4_new_addr",  ic_req_addr, 32'h100);
    wait_out_valid("t4_out_seen");
    check("t4_out_pc",    out_pc,      32'h100);
    check("t4_out_instr", out_instr,   32'hC2A5_0100);

    // 5a: redirect during a miss drains the refill then fetches the target
    check("t5a_ready", ic_req_ready, 1'b1);
    pulse_redirect(32'h40);
    check("t5a_miss_addr", ic_req_addr, 32'h40);
    step();
    check("t5a_busy", ic_req_ready, 1'b0);
    pulse_redirect(32'h200);
    wait_resp_holding("t5a_drain", 32'h40);
    step();
    check("t5a_target",  ic_req_addr, 32'h200);
    check("t5a_dropped", out_valid,   1'b0);
    wait_out_valid("t5a_out_seen");
    check("t5a_out_pc", out_pc, 32'h200);

    // 5b: a second redirect while draining replaces the pending target
    check("t5b_ready", ic_req_ready, 1'b1);
    pulse_redirect(32'h60);
    step();
    check("t5b_busy", ic_req_ready, 1'b0);
    pulse_redirect(32'h2E0);
    pulse_redirect(32'h300);
    wait_resp_holding("t5b_drain", 32'h60);
    step();
    check("t5b_target", ic_req_addr, 32'h300);
    wait_out_valid("t5b_out_seen");
    check("t5b_out_pc",    out_pc,    32'h300);
    check("t5b_out_instr", out_instr, 32'hC0A5_0300);

    // 6: reset in the middle of a miss clears outputs at once
    check("t6_ready", ic_req_ready, 1'b1);
    pulse_redirect(32'h80);
    step();
    check("t6_busy", ic_req_ready, 1'b0);
    reset = 1'b0;
    #1;
    check("t6_req_valid", ic_req_valid, 1'b0);
    check("t6_req_addr",  ic_req_addr,  32'h0);
    check("t6_out_valid", out_valid,    1'b0);
    check("t6_fq_count",  fq_count,     3'd0);
    step();
    step();
    reset = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ic_req_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("t6_req_seen", ok,            1'b1);
    check("t6_restart",  ic_req_addr,   32'h0);
    check("t6_warm_hit", ic_resp_valid, 1'b1);
    step();
    check("t6_out_pc", out_pc, 32'h0);

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

endmodule
